// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel
// ramp-limited pulse width and an IDLE/DRIVE state per channel.
module servo_pwm_multi #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned PWM_PERIOD = 2000000,
   parameter int unsigned PULSE_MIN  = 100000,
   parameter int unsigned PULSE_CTR  = 150000,
   parameter int unsigned PULSE_MAX  = 200000,
   parameter int unsigned RAMP_STEP  = 5000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] open,
   input  logic [NUM_CH-1:0] close,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_start,
   output logic [NUM_CH-1:0] at_target
);

   localparam int unsigned WW = $clog2(PWM_PERIOD + 1);

   localparam logic [WW-1:0] CNT_LAST = WW'(PWM_PERIOD - 1);
   localparam logic [WW-1:0] W_MIN    = WW'(PULSE_MIN);
   localparam logic [WW-1:0] W_CTR    = WW'(PULSE_CTR);
   localparam logic [WW-1:0] W_MAX    = WW'(PULSE_MAX);
   localparam logic [WW-1:0] W_STEP   = WW'(RAMP_STEP);

   typedef enum logic {IDLE, DRIVE} state_t;

   logic [WW-1:0] cnt;
   logic          boundary_c;
   logic [WW-1:0] width      [NUM_CH];
   logic [WW-1:0] width_nxt  [NUM_CH];
   logic [WW-1:0] tgt_c      [NUM_CH];
   logic [WW-1:0] ramp_c     [NUM_CH];
   state_t        state      [NUM_CH];
   state_t        state_nxt  [NUM_CH];
   logic [NUM_CH-1:0] at_nxt;

   assign boundary_c = (cnt == CNT_LAST);

   // Shared free-running frame counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (boundary_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + WW'(1);
      end
   end

   // Per-channel target decode, ramp step and state transitions (boundary only)
   always_comb begin
      at_nxt = at_target;
      for (int i = 0; i < NUM_CH; i++) begin
         tgt_c[i]     = W_CTR;
         ramp_c[i]    = width[i];
         width_nxt[i] = width[i];
         state_nxt[i] = state[i];

         if (close[i] && !open[i]) begin
            tgt_c[i] = W_MAX;
         end else if (open[i] && !close[i]) begin
            tgt_c[i] = W_MIN;
         end

         if (tgt_c[i] > width[i]) begin
            if ((W_STEP == '0) || ((tgt_c[i] - width[i]) <= W_STEP)) begin
               ramp_c[i] = tgt_c[i];
            end else begin
               ramp_c[i] = width[i] + W_STEP;
            end
         end else if (tgt_c[i] < width[i]) begin
            if ((W_STEP == '0) || ((width[i] - tgt_c[i]) <= W_STEP)) begin
               ramp_c[i] = tgt_c[i];
            end else begin
               ramp_c[i] = width[i] - W_STEP;
            end
         end

         if (boundary_c) begin
            if (ramp_c[i] < W_MIN) begin
               width_nxt[i] = W_MIN;
            end else if (ramp_c[i] > W_MAX) begin
               width_nxt[i] = W_MAX;
            end else begin
               width_nxt[i] = ramp_c[i];
            end
            at_nxt[i] = (width_nxt[i] == tgt_c[i]);

            case (state[i])
               IDLE: begin
                  if (tgt_c[i] != W_CTR) begin
                     state_nxt[i] = DRIVE;
                  end
               end
               DRIVE: begin
                  if ((tgt_c[i] == W_CTR) && (width_nxt[i] == W_CTR)) begin
                     state_nxt[i] = IDLE;
                  end
               end
               default: state_nxt[i] = IDLE;
            endcase
         end
      end
   end

   // Channel state and applied width registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= IDLE;
            width[i] <= W_CTR;
         end
         at_target <= '1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= state_nxt[i];
            width[i] <= width_nxt[i];
         end
         at_target <= at_nxt;
      end
   end

   // Pulse high for counter values 1..W; frame_start aligned with counter = 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out     <= '0;
         frame_start <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            pwm_out[i] <= (state[i] == DRIVE) && (cnt < width[i]);
         end
         frame_start <= (cnt == '0);
      end
   end

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent servo channels (1..16).
REQ-002 Parameter PWM_PERIOD, default 2000000, PWM frame length in clk cycles (20 ms at 100 MHz).
REQ-003 Parameter PULSE_MIN, default 100000, full-speed counter-clockwise pulse width in cycles (1.0 ms).
REQ-004 Parameter PULSE_CTR, default 150000, stop pulse width in cycles (1.5 ms).
REQ-005 Parameter PULSE_MAX, default 200000, full-speed clockwise pulse width in cycles (2.0 ms).
REQ-006 Parameter RAMP_STEP, default 5000, maximum pulse-width change per frame in cycles; 0 means no ramp limit.
REQ-007 clk  input  1  single system clock; all logic is on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 open  input  NUM_CH  per-channel request to rotate counter-clockwise.
REQ-010 close  input  NUM_CH  per-channel request to rotate clockwise.
REQ-011 pwm_out  output  NUM_CH  per-channel servo pulse, active high.
REQ-012 frame_start  output  1  one-cycle strobe marking the first cycle of each frame.
REQ-013 at_target  output  NUM_CH  high when the channel's applied width equals its target width.

Function
REQ-014 A single shared frame counter SHALL count 0..PWM_PERIOD-1 and then wrap to 0, free-running whenever rst is low.
REQ-015 Each channel's target SHALL be decoded as follows: close only gives PULSE_MAX; open only gives PULSE_MIN; neither or both gives PULSE_CTR.
REQ-016 open and close SHALL be sampled only in the cycle where counter = PWM_PERIOD-1, so input changes mid-frame have no effect until the next frame.
REQ-017 At that same cycle, each channel's applied width W SHALL move toward its target T. If |T-W| <= RAMP_STEP or RAMP_STEP = 0, W takes the value T. Otherwise W changes by ±RAMP_STEP.
REQ-018 W SHALL be held within [PULSE_MIN, PULSE_MAX] at all times, and all width arithmetic SHALL be unsigned at $clog2(PWM_PERIOD+1) bits with no overflow.
REQ-019 Each channel SHALL have two states:
- IDLE: pwm_out low.
- DRIVE: pulses generated.
REQ-020 A channel SHALL move IDLE->DRIVE at a frame boundary when the sampled target is not PULSE_CTR.
REQ-021 A channel SHALL move DRIVE->IDLE at a frame boundary when both the sampled target and the updated W equal PULSE_CTR.
REQ-022 In DRIVE, pwm_out SHALL be registered and high for exactly W consecutive cycles, starting one cycle after counter = 0, and low for the rest of the frame.
REQ-023 A new W SHALL take effect from the next frame only; a pulse in progress is never truncated or extended.
REQ-024 frame_start SHALL be a registered one-cycle pulse, aligned with the first high cycle of any pulse in that frame.
REQ-025 at_target SHALL be registered and updated at each frame boundary.
REQ-026 Channels SHALL be fully independent; simultaneous requests on all channels cause no interaction.
REQ-027 Reversing direction (PULSE_MIN target while W > PULSE_CTR) SHALL ramp through PULSE_CTR without skipping, at RAMP_STEP per frame.

Reset
REQ-028 While rst is high, the following SHALL hold: counter = 0, W = PULSE_CTR, all channels IDLE, pwm_out = 0, frame_start = 0, at_target = all ones.
REQ-029 rst asserted mid-pulse SHALL drive pwm_out low asynchronously.
REQ-030 After rst is released, the first frame SHALL begin at counter = 0 on the next clk edge.

Verification (bench parameters: NUM_CH=2, PWM_PERIOD=100, PULSE_MIN=10, PULSE_CTR=15, PULSE_MAX=20, RAMP_STEP=2)
REQ-031 Reset only, no requests, 3 frames -> pwm_out = 00 throughout, frame_start every 100 cycles, at_target = 11.
REQ-032 close[0] held from reset -> ch0 widths 17, 19, 20, 20 over frames 1-4; at_target[0] = 1 from frame 3; ch1 stays low.
REQ-033 close[0] toggled to open[0] at counter = 50 of a frame at width 20 -> current pulse unchanged; later widths 18, 16, 14, 12, 10.
REQ-034 open[1] and close[1] both high while ch1 is at width 10 -> widths 12, 14, 15, then ch1 IDLE with pwm_out[1] = 0.
REQ-035 rst pulsed during a ch0 high phase -> pwm_out[0] falls in the same cycle; after release, W = 15 and ramping restarts from 15.
REQ-036 RAMP_STEP=0 with close[0] held -> first driven frame has a width of exactly 20 cycles.
